alu_operand_loader: RTL and testbench

- Front-end initiator that drives the team's 4-bit ALU (operands a, b, opcode select) from board switches and one push button.
- Sequences the entry of A, then B, then opcode, then waits for the ALU's registered result.
- Captures the result and its flags (zero, carry, overflow, compare) into holding registers for display and debug.
- Sits between the board I/O and the ALU instance at the top level.

---
 rtl/alu_operand_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_operand_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// ============================================================================
// Module   : alu_operand_loader
// Purpose  : Board front end for the 4-bit ALU. A debounced push button
//            steps through loading operand A, operand B and the opcode from
//            the switches, waits for the registered ALU result, then
//            captures the result and flags for display.
// Ports    : clk, rst_n (sync, active-low), btn (raw async button),
//            btn_clr (abort strobe), sw[3:0] (operand/opcode switches),
//            alu_result/alu_zero/alu_cin/alu_overflow/alu_cmp (from ALU),
//            alu_a/alu_b/alu_sel (to ALU), res_q/flags_q (captured result,
//            flags = {overflow,cin,zero,cmp}), valid, done (capture pulse),
//            state_q (FSM encoding for LEDs).
// Options  : ALU_LOADER_CHECK_EN adds a sticky 'mismatch' output that
//            compares the captured ALU result against an internal reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ALU_LATENCY     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       btn_clr,
  input  logic [3:0] sw,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_cin,
  input  logic       alu_overflow,
  input  logic       alu_cmp,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  output logic [3:0] res_q,
  output logic [3:0] flags_q,
  output logic       valid,
  output logic       done,
  output logic [2:0] state_q
`ifdef ALU_LOADER_CHECK_EN
  ,
  output logic       mismatch
`endif
);

  localparam int C_CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [C_CNT_W-1:0]  C_CNT_MAX  = C_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_WAIT_W-1:0] C_WAIT_MAX = C_WAIT_W'(ALU_LATENCY - 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    ISSUE   = 3'd3,
    WAIT    = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6
  } state_e;

  // Button front end
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               deb_q, deb_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               press_q, press_d;

  // Sequencer
  state_e              st_q, st_d;
  logic [C_WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]          alu_a_q, alu_a_d;
  logic [3:0]          alu_b_q, alu_b_d;
  logic [2:0]          alu_sel_q, alu_sel_d;
  logic [3:0]          res_d;
  logic [3:0]          flags_d;
  logic                valid_q, valid_d;

  // The debounced level only follows the synchronized level once the two
  // have disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreeing
  // cycle restarts the count. press fires on the cycle the level rises.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == C_CNT_MAX) begin
        deb_d   = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    st_d      = st_q;
    wait_d    = wait_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    res_d     = res_q;
    flags_d   = flags_q;
    valid_d   = valid_q;
    done      = 1'b0;

    case (st_q)
      LOAD_A: if (press_q) begin
        alu_a_d = sw;
        st_d    = LOAD_B;
      end
      LOAD_B: if (press_q) begin
        alu_b_d = sw;
        st_d    = LOAD_OP;
      end
      LOAD_OP: if (press_q) begin
        alu_sel_d = sw[2:0];
        st_d      = ISSUE;
      end
      ISSUE: begin
        wait_d = '0;
        st_d   = WAIT;
      end
      WAIT: begin
        if (wait_q == C_WAIT_MAX) begin
          st_d = CAPTURE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      CAPTURE: begin
        res_d   = alu_result;
        flags_d = {alu_overflow, alu_cin, alu_zero, alu_cmp};
        valid_d = 1'b1;
        done    = 1'b1;
        st_d    = DONE;
      end
      DONE: if (press_q) begin
        valid_d = 1'b0;
        st_d    = LOAD_A;
      end
      default: st_d = LOAD_A;
    endcase

    // Abort overrides whatever the state would have done this cycle,
    // including a coincident press or an in-flight capture. Loaded
    // operands are left untouched.
    if (btn_clr && (st_q != LOAD_A)) begin
      st_d      = LOAD_A;
      valid_d   = 1'b0;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      res_d     = res_q;
      flags_d   = flags_q;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      st_q      <= LOAD_A;
      wait_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      st_q      <= st_d;
      wait_q    <= wait_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      valid_q   <= valid_d;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign valid   = valid_q;
  assign state_q = st_q;

`ifdef ALU_LOADER_CHECK_EN
  logic       mismatch_q, mismatch_d;
  logic [3:0] ref_res;
  logic       ref_ok;

  // Opcodes 6 and 7 have no reference and are never flagged.
  always_comb begin
    ref_res = '0;
    ref_ok  = 1'b1;
    case (alu_sel_q)
      3'd0:    ref_res = alu_a_q + alu_b_q;
      3'd1:    ref_res = alu_a_q - alu_b_q;
      3'd2:    ref_res = ~alu_a_q;
      3'd3:    ref_res = alu_a_q & alu_b_q;
      3'd4:    ref_res = alu_a_q | alu_b_q;
      3'd5:    ref_res = alu_a_q ^ alu_b_q;
      default: ref_ok  = 1'b0;
    endcase
  end

  always_comb begin
    mismatch_d = mismatch_q;
    if (btn_clr) begin
      mismatch_d = 1'b0;
    end else if ((st_q == CAPTURE) && ref_ok && (alu_result != ref_res)) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ============================================================================
// Module   : tb_alu_operand_loader
// Purpose  : Self-checking bench for alu_operand_loader. A behavioural ALU
//            (registered, one cycle) feeds the DUT; expected captures come
//            from a plain-arithmetic ALU reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_loader;

  localparam int DEB = 4;
  localparam int LAT = 2;
  localparam int HOLD = DEB + 6;

  logic       clk = 1'b0;
  logic       rst_n, btn, btn_clr;
  logic [3:0] sw;
  logic [3:0] alu_result;
  logic       alu_zero, alu_cin, alu_overflow, alu_cmp;
  logic [3:0] alu_a, alu_b, res_q, flags_q;
  logic [2:0] alu_sel, state_q;
  logic       valid, done;
`ifdef ALU_LOADER_CHECK_EN
  logic       mismatch;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  logic force_bad = 1'b0;

  always #5 clk = ~clk;

  alu_operand_loader #(.DEBOUNCE_CYCLES(DEB), .ALU_LATENCY(LAT)) dut (
`ifdef ALU_LOADER_CHECK_EN
    .mismatch     (mismatch),
`endif
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .btn_clr      (btn_clr),
    .sw           (sw),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cin      (alu_cin),
    .alu_overflow (alu_overflow),
    .alu_cmp      (alu_cmp),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .res_q        (res_q),
    .flags_q      (flags_q),
    .valid        (valid),
    .done         (done),
    .state_q      (state_q)
  );

  // Reference ALU: returns {overflow, carry, zero, cmp, result[3:0]}.
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
    int ai, bi, sa, sb, r;
    logic c, v;
    logic [3:0] res;
    ai = int'(a);
    bi = int'(b);
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    c = 1'b0;
    v = 1'b0;
    case (sel)
      3'd0: begin r = ai + bi; c = (r > 15); v = (sa + sb > 7) || (sa + sb < -8); end
      3'd1: begin r = ai - bi; c = (ai < bi); v = (sa - sb > 7) || (sa - sb < -8); end
      3'd2: r = 15 - ai;
      3'd3: r = ai & bi;
      3'd4: r = ai | bi;
      3'd5: r = ai ^ bi;
      3'd6: begin r = ai * 2; c = (ai >= 8); end
      default: r = bi;
    endcase
    res = 4'(r & 15);
    return {v, c, (res == 4'd0), (ai > bi), res};
  endfunction

  // Behavioural ALU with one register stage.
  logic [7:0] alu_q = 8'd0;
  always @(posedge clk) alu_q <= alu_model(alu_a, alu_b, alu_sel);
  assign alu_result   = force_bad ? 4'd9 : alu_q[3:0];
  assign alu_cmp      = alu_q[4];
  assign alu_zero     = alu_q[5];
  assign alu_cin      = alu_q[6];
  assign alu_overflow = alu_q[7];

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit);
    int n = 0;
    while (state_q !== s && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", 32'(state_q), 32'(s));
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    sw = a;        press();
    sw = b;        press();
    sw = {1'b0, sel}; press();
    wait_state(3'd6, 40);
  endtask

  // Runs one operation and checks every observable against the reference.
  task automatic check_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] sel);
    logic [7:0] e;
    int d0;
    e = alu_model(a, b, sel);
    d0 = done_cnt;
    do_op(a, b, sel);
    chk({tag, "_res"},   32'(res_q),   32'(e[3:0]));
    chk({tag, "_flags"}, 32'(flags_q), 32'(e[7:4]));
    chk({tag, "_valid"}, 32'(valid),   32'd1);
    chk({tag, "_done"},  32'(done_cnt - d0), 32'd1);
    chk({tag, "_a"},     32'(alu_a),   32'(a));
    chk({tag, "_b"},     32'(alu_b),   32'(b));
    chk({tag, "_sel"},   32'(alu_sel), 32'(sel));
`ifdef ALU_LOADER_CHECK_EN
    if (!force_bad) chk({tag, "_mismatch"}, 32'(mismatch), 32'd0);
`endif
  endtask

  task automatic leave_done(input string tag);
    press();
    chk({tag, "_ret_state"}, 32'(state_q), 32'd0);
    chk({tag, "_ret_valid"}, 32'(valid),   32'd0);
  endtask

  initial begin
    int lat;
    int d0;
    logic [3:0] ra, rb;
    logic [2:0] rs;
    logic [3:0] prev_b;

    rst_n = 1'b0; btn = 1'b0; btn_clr = 1'b0; sw = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_q), 32'd0);
    chk("rst_outs",  32'({alu_a, alu_b, alu_sel, res_q, flags_q, valid, done}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed operations from the plan.
    check_op("add_3_4", 4'd3, 4'd4, 3'd0);
    chk("add_3_4_res7",   32'(res_q),   32'd7);
    chk("add_3_4_flags0", 32'(flags_q), 32'd0);
    chk("add_3_4_state6", 32'(state_q), 32'd6);
    leave_done("add_3_4");

    check_op("add_7_1", 4'd7, 4'd1, 3'd0);
    chk("add_7_1_res8", 32'(res_q), 32'd8);
    chk("add_7_1_ovf",  32'(flags_q[3]), 32'd1);
    // Abort from DONE clears valid without a press.
    btn_clr = 1'b1; @(negedge clk); btn_clr = 1'b0;
    chk("clr_done_state", 32'(state_q), 32'd0);
    chk("clr_done_valid", 32'(valid),   32'd0);
    chk("clr_done_res",   32'(res_q),   32'd8);
    repeat (2) @(negedge clk);

    check_op("sub_5_5", 4'd5, 4'd5, 3'd1);
    chk("sub_5_5_res0", 32'(res_q), 32'd0);
    chk("sub_5_5_zero", 32'(flags_q[1]), 32'd1);
    leave_done("sub_5_5");

    // Bouncing button never settles long enough to register.
    sw = 4'hC;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (3) @(negedge clk);
    end
    btn = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("bounce_state", 32'(state_q), 32'd0);
    chk("bounce_a",     32'(alu_a),   32'd5);
    // A clean 10-cycle hold gives exactly one press.
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("one_press_state", 32'(state_q), 32'd1);
    chk("one_press_a",     32'(alu_a),   32'hC);

    // Measure button-to-state-change latency while loading B.
    sw = 4'h6;
    btn = 1'b1;
    lat = 0;
    while (state_q !== 3'd2 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("press_latency_ok", 32'((lat >= 2 + DEB) && (lat <= 2 + DEB + 3)), 32'd1);
    repeat (HOLD) @(negedge clk);
    btn = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("loadb_b", 32'(alu_b), 32'h6);

    // Abort coinciding with the press in LOAD_OP.
    prev_b = alu_b;
    sw = 4'h6;
    btn = 1'b1;
    repeat (lat - 1) @(negedge clk);
    btn_clr = 1'b1;
    @(negedge clk);
    btn_clr = 1'b0;
    chk("clr_press_state_now", 32'(state_q), 32'd0);
    repeat (HOLD) @(negedge clk);
    btn = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("clr_press_state", 32'(state_q), 32'd0);
    chk("clr_press_valid", 32'(valid),   32'd0);
    chk("clr_press_sel",   32'(alu_sel), 32'd1);
    chk("clr_press_b",     32'(alu_b),   32'(prev_b));

    // Reset in the middle of WAIT.
    sw = 4'd2; press();
    sw = 4'd9; press();
    sw = 4'd0;
    btn = 1'b1;
    wait_state(3'd4, 30);
    d0 = done_cnt;
    rst_n = 1'b0;
    btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("wait_rst_state", 32'(state_q), 32'd0);
    chk("wait_rst_outs",  32'({alu_a, alu_b, alu_sel, res_q, flags_q, valid, done}), 32'd0);
    repeat (10) @(negedge clk);
    chk("wait_rst_nodone",  32'(done_cnt - d0), 32'd0);
    chk("wait_rst_state2",  32'(state_q), 32'd0);
`ifdef ALU_LOADER_CHECK_EN
    chk("wait_rst_mismatch", 32'(mismatch), 32'd0);
`endif

    // Randomized operations.
    for (int i = 0; i < 8; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      check_op($sformatf("rnd%0d", i), ra, rb, rs);
      leave_done($sformatf("rnd%0d", i));
    end

`ifdef ALU_LOADER_CHECK_EN
    force_bad = 1'b1;
    check_op("bad_add", 4'd3, 4'd4, 3'd0);
    force_bad = 1'b0;
    chk("mismatch_set", 32'(mismatch), 32'd1);
    leave_done("bad_add");
    chk("mismatch_sticky", 32'(mismatch), 32'd1);
    btn_clr = 1'b1; @(negedge clk); btn_clr = 1'b0;
    chk("mismatch_clr", 32'(mismatch), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
